// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage LEGv8 pipeline: load-use and flag stalls,
// taken-branch flush, and EX operand forwarding from an EX/MEM/WB scoreboard.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             id_setflag,
    input  logic             id_is_blt,
    input  logic             ex_br_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
        logic       setflag;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       uses_rn;
        logic       uses_rm;
    } sb_entry_t;

    localparam logic [4:0]       XZR      = 5'd31;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [1:0]       FWD_RF   = 2'b00;
    localparam logic [1:0]       FWD_MEM  = 2'b01;
    localparam logic [1:0]       FWD_WB   = 2'b10;
    localparam sb_entry_t        SB_EMPTY = '0;

    // X31 is the zero register: a write to it never creates a dependency.
    function automatic logic reg_match(input sb_entry_t prod, input logic [4:0] src,
                                       input logic src_used);
        return prod.valid && prod.regwrite && (prod.rd != XZR) && src_used && (prod.rd == src);
    endfunction

    // A load still in MEM has no data yet, so only WB may supply its result.
    function automatic logic [1:0] fwd_sel(input sb_entry_t mem, input sb_entry_t wb,
                                           input logic [4:0] src, input logic src_used);
        logic [1:0] sel;
        if (!mem.load && reg_match(mem, src, src_used)) begin
            sel = FWD_MEM;
        end else if (reg_match(wb, src, src_used)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    sb_entry_t        r_ex;
    sb_entry_t        r_mem;
    sb_entry_t        r_wb;
    sb_entry_t        w_id_entry;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;
    logic             w_flag_stall;
    logic             w_stall;
    logic             w_idex_bubble;
    logic             w_unused;

    assign w_load_use   = id_valid && r_ex.load &&
                          (reg_match(r_ex, id_rn, id_uses_rn) || reg_match(r_ex, id_rm, id_uses_rm));
    assign w_flag_stall = id_valid && id_is_blt && r_ex.valid && r_ex.setflag;
    assign w_stall      = w_load_use || w_flag_stall;

    // Pipeline enables; a taken branch wins over a stall, reset forces free-run.
    always_comb begin
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b0;
        w_idex_bubble = 1'b0;
        if (reset) begin
            pc_en         = 1'b1;
        end else if (ex_br_taken) begin
            ifid_flush    = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_stall) begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            w_idex_bubble = 1'b1;
        end else begin
            w_idex_bubble = 1'b0;
        end
    end

    assign idex_bubble = w_idex_bubble;

    // Operand source selection for the instruction currently in EX.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (!reset && r_ex.valid) begin
            fwd_a = fwd_sel(r_mem, r_wb, r_ex.rn, r_ex.uses_rn);
            fwd_b = fwd_sel(r_mem, r_wb, r_ex.rm, r_ex.uses_rm);
        end else begin
            fwd_a = FWD_RF;
            fwd_b = FWD_RF;
        end
    end

    // Decode fields captured into the EX slot; bubbles and empty slots go in invalid.
    always_comb begin
        w_id_entry          = SB_EMPTY;
        w_id_entry.valid    = id_valid && !w_idex_bubble;
        w_id_entry.rd       = id_rd;
        w_id_entry.regwrite = id_regwrite;
        w_id_entry.load     = id_is_load;
        w_id_entry.setflag  = id_setflag;
        w_id_entry.rn       = id_rn;
        w_id_entry.rm       = id_rm;
        w_id_entry.uses_rn  = id_uses_rn;
        w_id_entry.uses_rm  = id_uses_rm;
    end

    // Scoreboard shift register mirroring the EX/MEM/WB pipeline registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex  <= SB_EMPTY;
            r_mem <= SB_EMPTY;
            r_wb  <= SB_EMPTY;
        end else begin
            r_ex  <= w_id_entry;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    // Saturating stall counter; cycles consumed by a branch flush are not stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= CNT_ZERO;
        end else if (w_stall && !ex_br_taken && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_cnt = r_stall_cnt;

    // MEM/WB source fields are carried for completeness but not consumed here.
    assign w_unused = ^{r_mem, r_wb};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stalls, flush, forwarding, X31,
// counter saturation (narrow-counter second instance) and reset mid-stall.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       id_uses_rn, id_uses_rm, id_regwrite, id_is_load, id_setflag, id_is_blt;
    logic       ex_br_taken;

    logic        pc_en, ifid_en, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [2:0]  s_stall_cnt;

    logic [3:0] ctl;
    logic [3:0] fwd;
    assign ctl = {pc_en, ifid_en, ifid_flush, idex_bubble};
    assign fwd = {fwd_a, fwd_b};

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_setflag(id_setflag),
        .id_is_blt(id_is_blt), .ex_br_taken(ex_br_taken), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_setflag(id_setflag),
        .id_is_blt(id_is_blt), .ex_br_taken(ex_br_taken), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                            input logic urn, input logic urm, input logic [4:0] rd,
                            input logic rw, input logic ld, input logic sf, input logic blt);
        id_valid = v; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
        id_rd = rd; id_regwrite = rw; id_is_load = ld; id_setflag = sf; id_is_blt = blt;
    endtask

    task automatic idle;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ex_br_taken = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        cyc();
        cyc();
        ex_br_taken = 1'b1;
        drive_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL rst_ctl got %b want %b", ctl, 4'b1100); end
        n_cmp++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL rst_fwd got %b want %b", fwd, 4'b0000); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", stall_cnt); end
        idle();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_load_use;
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);   // LDUR X2
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL lu_ld_ctl got %b want %b", ctl, 4'b1100); end
        cyc();
        drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X3,X2,X4
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b0001) begin n_fail++; $display("FAIL lu_stall_ctl got %b want %b", ctl, 4'b0001); end
        cyc();
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL lu_release_ctl got %b want %b", ctl, 4'b1100); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
        cyc();
        idle();
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b1000) begin n_fail++; $display("FAIL lu_fwd got %b want %b", fwd, 4'b1000); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt); end
        cyc();
    endtask

    task automatic test_back_to_back;
        do_reset();
        drive_id(1'b1, 5'd6, 5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);   // ADDS X1,X6,X7
        cyc();
        drive_id(1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);   // SUBS X5,X1,X1
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL b2b_nostall got %b want %b", ctl, 4'b1100); end
        cyc();
        drive_id(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X8,X1,X9
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b0101) begin n_fail++; $display("FAIL b2b_fwd_mem got %b want %b", fwd, 4'b0101); end
        cyc();
        idle();
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b1000) begin n_fail++; $display("FAIL b2b_fwd_wb got %b want %b", fwd, 4'b1000); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_cnt got %0d want 0", stall_cnt); end
        cyc();
    endtask

    task automatic test_fwd_priority;
        do_reset();
        drive_id(1'b1, 5'd11, 5'd12, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X10
        cyc();
        cyc();                                                                    // ADD X10 again
        drive_id(1'b1, 5'd10, 5'd10, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X13,X10,X10
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL pri_nostall got %b want %b", ctl, 4'b1100); end
        cyc();
        idle();
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b0101) begin n_fail++; $display("FAIL pri_mem_over_wb got %b want %b", fwd, 4'b0101); end
        cyc();
    endtask

    task automatic test_flag;
        do_reset();
        drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);   // SUBS X0,X1,X2
        cyc();
        drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);   // B.LT
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b0001) begin n_fail++; $display("FAIL flag_stall got %b want %b", ctl, 4'b0001); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL flag_cnt_before got %0d want 0", stall_cnt); end
        cyc();
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL flag_proceed got %b want %b", ctl, 4'b1100); end
        n_cmp++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL flag_cnt_after got %0d want 1", stall_cnt); end
        cyc();
        idle();
    endtask

    task automatic test_branch_over_stall;
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);   // LDUR X2
        cyc();
        drive_id(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X3,X2,X4
        ex_br_taken = 1'b1;
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1111) begin n_fail++; $display("FAIL br_ctl got %b want %b", ctl, 4'b1111); end
        cyc();
        idle();
        @(negedge clk);
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL br_cnt got %0d want 0", stall_cnt); end
        cyc();
    endtask

    task automatic test_x31;
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);  // LDUR X31
        cyc();
        drive_id(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X31,X31,X31
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL x31_nostall got %b want %b", ctl, 4'b1100); end
        cyc();
        drive_id(1'b1, 5'd31, 5'd31, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);  // SUB X4,X31,X31
        cyc();
        idle();
        @(negedge clk);
        n_cmp++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL x31_fwd got %b want %b", fwd, 4'b0000); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL x31_cnt got %0d want 0", stall_cnt); end
        cyc();
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); // SUBS
            cyc();
            drive_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); // B.LT
            @(negedge clk);
            n_cmp++; if (ctl !== 4'b0001) begin n_fail++; $display("FAIL sat_stall_%0d got %b want %b", i, ctl, 4'b0001); end
            cyc();
            cyc();
            if (i == 7) begin
                n_cmp++; if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_reach got %0d want 7", s_stall_cnt); end
            end
        end
        n_cmp++; if (s_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold got %0d want 7", s_stall_cnt); end
        n_cmp++; if (stall_cnt !== 16'd10) begin n_fail++; $display("FAIL sat_wide got %0d want 10", stall_cnt); end
        idle();
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        drive_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);   // LDUR X2
        cyc();
        drive_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X3,X2,X2
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b0001) begin n_fail++; $display("FAIL rms_stall got %b want %b", ctl, 4'b0001); end
        reset = 1'b1;
        #1;
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL rms_during got %b want %b", ctl, 4'b1100); end
        cyc();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (ctl !== 4'b1100) begin n_fail++; $display("FAIL rms_after_ctl got %b want %b", ctl, 4'b1100); end
        n_cmp++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rms_cnt got %0d want 0", stall_cnt); end
        n_cmp++; if (fwd !== 4'b0000) begin n_fail++; $display("FAIL rms_fwd got %b want %b", fwd, 4'b0000); end
        cyc();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_fwd_priority();
        test_flag();
        test_branch_over_stall();
        test_x31();
        test_saturation();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
